// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the 32-point SDF FFT pipeline.
//   SEL_*              : select codes understood by the downstream MUX_4x1
//   DATA_WIDTH_DEFAULT : default width of one real/imaginary component
//   clog2()            : ceiling log2, usable in constant expressions
package fft_pkg;

  localparam logic [1:0] SEL_IN   = 2'b00;
  localparam logic [1:0] SEL_DLY  = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_DIFF = 2'b11;

  localparam int DATA_WIDTH_DEFAULT = 16;

  // Returns at least 1 so a 1-entry range still gets a 1-bit counter.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// sdf_stage_ctrl_if: sample stream into one SDF stage and the candidate
// buses it presents to MUX_4x1.
//   in_valid/in_re/in_im : input sample, accepted on every rising edge
//                          with in_valid high (no backpressure, no ready)
//   A..D (re/im)         : registered candidate buses
//   sel                  : MUX_4x1 select, qualified by out_valid
//   out_valid            : candidates/sel are a new output this cycle
//   frame_start          : first output sample of a frame
// Handshake: in_valid is a one-way strobe; the stage always accepts.
// out_valid is a one-way strobe; the consumer must take the outputs in
// the cycle they are presented.
interface sdf_stage_ctrl_if
  import fft_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEFAULT
);
  logic                  in_valid;
  logic [data_width-1:0] in_re;
  logic [data_width-1:0] in_im;
  logic [data_width-1:0] A_re;
  logic [data_width-1:0] A_im;
  logic [data_width-1:0] B_re;
  logic [data_width-1:0] B_im;
  logic [data_width-1:0] C_re;
  logic [data_width-1:0] C_im;
  logic [data_width-1:0] D_re;
  logic [data_width-1:0] D_im;
  logic [1:0]            sel;
  logic                  out_valid;
  logic                  frame_start;

  modport master (
    output in_valid, in_re, in_im,
    input  A_re, A_im, B_re, B_im, C_re, C_im, D_re, D_im,
    input  sel, out_valid, frame_start
  );

  modport slave (
    input  in_valid, in_re, in_im,
    output A_re, A_im, B_re, B_im, C_re, C_im, D_re, D_im,
    output sel, out_valid, frame_start
  );
endinterface

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: DEPTH-entry complex shift register with async clear.
//   clk, rst_n        : clock, asynchronous active-low clear
//   en                : shift one position
//   din_re/din_im     : value entering the head
//   dout_re/dout_im   : tail (value written DEPTH shifts ago)
module sdf_delay_line #(
  parameter int data_width = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [data_width-1:0] din_re,
  input  logic [data_width-1:0] din_im,
  output logic [data_width-1:0] dout_re,
  output logic [data_width-1:0] dout_im
);

  logic [data_width-1:0] sr_re [DEPTH];
  logic [data_width-1:0] sr_im [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_re[i] <= '0;
        sr_im[i] <= '0;
      end
    end else if (en) begin
      sr_re[0] <= din_re;
      sr_im[0] <= din_im;
      for (int i = 1; i < DEPTH; i++) begin
        sr_re[i] <= sr_re[i-1];
        sr_im[i] <= sr_im[i-1];
      end
    end
  end

  assign dout_re = sr_re[DEPTH-1];
  assign dout_im = sr_im[DEPTH-1];

endmodule

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: radix-2 SDF stage controller feeding MUX_4x1.
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : sdf_stage_ctrl_if.slave (input stream, candidate buses,
//                sel, out_valid, frame_start)
// Each frame is 2*DEPTH samples: the first DEPTH fill the delay line while
// the previous frame's differences drain out on B; the last DEPTH are
// butterflied against the delayed samples, the scaled sum leaves on C and
// the scaled difference is stored back for the next fill phase.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sdf_stage_ctrl_if.slave  bus
);

  localparam int             CW         = clog2(2 * DEPTH);
  localparam logic [CW-1:0]  CNT_BFLY_0 = CW'(DEPTH);

  logic [CW-1:0]         cnt;
  logic                  primed;
  logic                  phase;
  logic                  primed_nxt;
  logic [data_width-1:0] dly_re, dly_im;
  logic [data_width-1:0] dl_din_re, dl_din_im;
  logic [data_width:0]   sum_re, sum_im, diff_re, diff_im;

  assign phase      = cnt[CW-1];
  // The sample that makes phase 1 for the first time is already an output.
  assign primed_nxt = primed | phase;

  // One extra bit so the add/subtract cannot overflow before halving.
  assign sum_re  = {dly_re[data_width-1], dly_re} + {bus.in_re[data_width-1], bus.in_re};
  assign sum_im  = {dly_im[data_width-1], dly_im} + {bus.in_im[data_width-1], bus.in_im};
  assign diff_re = {dly_re[data_width-1], dly_re} - {bus.in_re[data_width-1], bus.in_re};
  assign diff_im = {dly_im[data_width-1], dly_im} - {bus.in_im[data_width-1], bus.in_im};

  assign dl_din_re = phase ? diff_re[data_width:1] : bus.in_re;
  assign dl_din_im = phase ? diff_im[data_width:1] : bus.in_im;

  sdf_delay_line #(
    .data_width (data_width),
    .DEPTH      (DEPTH)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.in_valid),
    .din_re  (dl_din_re),
    .din_im  (dl_din_im),
    .dout_re (dly_re),
    .dout_im (dly_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      primed          <= 1'b0;
      bus.A_re        <= '0;
      bus.A_im        <= '0;
      bus.B_re        <= '0;
      bus.B_im        <= '0;
      bus.C_re        <= '0;
      bus.C_im        <= '0;
      bus.D_re        <= '0;
      bus.D_im        <= '0;
      bus.sel         <= SEL_IN;
      bus.out_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.out_valid   <= bus.in_valid & primed_nxt;
      bus.frame_start <= bus.in_valid & primed_nxt & (cnt == CNT_BFLY_0);
      if (bus.in_valid) begin
        // Power-of-two frame length: natural rollover is the wrap.
        cnt      <= cnt + CW'(1);
        primed   <= primed_nxt;
        bus.A_re <= bus.in_re;
        bus.A_im <= bus.in_im;
        bus.B_re <= dly_re;
        bus.B_im <= dly_im;
        // Arithmetic shift right by one: drop the LSB of the wide result.
        bus.C_re <= sum_re[data_width:1];
        bus.C_im <= sum_im[data_width:1];
        bus.D_re <= diff_re[data_width:1];
        bus.D_im <= diff_im[data_width:1];
        if (!primed_nxt) bus.sel <= SEL_IN;
        else if (phase)  bus.sel <= SEL_SUM;
        else             bus.sel <= SEL_DLY;
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
module tb_sdf_stage_ctrl;
  localparam int W  = 8;
  localparam int EW = 8 * W + 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_re, in_im;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdf_stage_ctrl_if #(.data_width(W)) bus4 ();
  sdf_stage_ctrl_if #(.data_width(W)) bus1 ();

  assign bus4.in_valid = in_valid;
  assign bus4.in_re    = in_re;
  assign bus4.in_im    = in_im;
  assign bus1.in_valid = in_valid;
  assign bus1.in_re    = in_re;
  assign bus1.in_im    = in_im;

  sdf_stage_ctrl #(.data_width(W), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  sdf_stage_ctrl #(.data_width(W), .DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // ---------------- reference model ----------------
  // Frame view: a sample's position k in the stream since reset gives its
  // phase (k/DEPTH odd = butterfly). The delay line is a FIFO of DEPTH values.
  int depth_of [2] = '{4, 1};
  int fifo_re [2][16];
  int fifo_im [2][16];
  int ptr [2];
  int k [2];
  logic [EW-1:0] exp_q0 [$];
  logic [EW-1:0] exp_q1 [$];
  logic [EW-1:0] hold_exp [2];

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 16; i++) begin
        fifo_re[n][i] = 0;
        fifo_im[n][i] = 0;
      end
      ptr[n] = 0;
      k[n] = 0;
      hold_exp[n] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_step(input int n, input int x_re, input int x_im);
    int d, o_re, o_im, s_re, s_im, f_re, f_im, sel_v;
    bit ph, pr, fs;
    logic [EW-1:0] v;
    d    = depth_of[n];
    o_re = fifo_re[n][ptr[n]];
    o_im = fifo_im[n][ptr[n]];
    ph   = ((k[n] / d) % 2) == 1;
    pr   = k[n] >= d;
    s_re = (o_re + x_re) >>> 1;
    s_im = (o_im + x_im) >>> 1;
    f_re = (o_re - x_re) >>> 1;
    f_im = (o_im - x_im) >>> 1;
    sel_v = !pr ? 0 : (ph ? 2 : 1);
    fs   = pr && ((k[n] % (2 * d)) == d);
    v = {W'(x_re), W'(x_im), W'(o_re), W'(o_im), W'(s_re), W'(s_im),
         W'(f_re), W'(f_im), 2'(sel_v), fs};
    fifo_re[n][ptr[n]] = ph ? f_re : x_re;
    fifo_im[n][ptr[n]] = ph ? f_im : x_im;
    ptr[n] = (ptr[n] + 1) % d;
    k[n]++;
    if (pr) begin
      if (n == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
    end else begin
      hold_exp[n] = v;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit v, input int re, input int im);
    in_valid = v;
    in_re    = W'(re);
    in_im    = W'(im);
    @(posedge clk);
    if (v) begin
      model_step(0, $signed(in_re), $signed(in_im));
      model_step(1, $signed(in_re), $signed(in_im));
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_seq(input int vals [$]);
    foreach (vals[i]) cycle(1'b1, vals[i], 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  int c_log0 [$], b_log0 [$], d_log0 [$], fs_log0 [$];
  int c_log1 [$], b_log1 [$], sel_log1 [$];

  task automatic clear_logs();
    c_log0.delete(); b_log0.delete(); d_log0.delete(); fs_log0.delete();
    c_log1.delete(); b_log1.delete(); sel_log1.delete();
  endtask

  task automatic check_obs(input int n, input logic [EW-1:0] obs, input logic ov);
    logic [EW-1:0] e;
    int sz;
    sz = (n == 0) ? exp_q0.size() : exp_q1.size();
    checks++;
    if (ov) begin
      if (sz == 0) begin
        errors++;
        $display("FAIL unexpected_valid inst%0d got=%h required=no output", n, obs);
      end else begin
        e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        hold_exp[n] = {e[EW-1:1], 1'b0};
        if (obs !== e) begin
          errors++;
          $display("FAIL output inst%0d got=%h required=%h", n, obs, e);
        end
      end
    end else if (sz != 0) begin
      e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      hold_exp[n] = {e[EW-1:1], 1'b0};
      errors++;
      $display("FAIL missing_valid inst%0d got=%h required=%h", n, obs, e);
    end else if (obs !== hold_exp[n]) begin
      errors++;
      $display("FAIL held inst%0d got=%h required=%h", n, obs, hold_exp[n]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_obs(0, {bus4.A_re, bus4.A_im, bus4.B_re, bus4.B_im, bus4.C_re, bus4.C_im,
                    bus4.D_re, bus4.D_im, bus4.sel, bus4.frame_start}, bus4.out_valid);
      check_obs(1, {bus1.A_re, bus1.A_im, bus1.B_re, bus1.B_im, bus1.C_re, bus1.C_im,
                    bus1.D_re, bus1.D_im, bus1.sel, bus1.frame_start}, bus1.out_valid);
      if (bus4.out_valid) begin
        if (bus4.sel == 2'b10) begin
          c_log0.push_back($signed(bus4.C_re));
          d_log0.push_back($signed(bus4.D_re));
        end
        if (bus4.sel == 2'b01) b_log0.push_back($signed(bus4.B_re));
        if (bus4.frame_start) fs_log0.push_back($signed(bus4.C_re));
      end
      if (bus1.out_valid) begin
        sel_log1.push_back(int'(bus1.sel));
        if (bus1.sel == 2'b10) c_log1.push_back($signed(bus1.C_re));
        if (bus1.sel == 2'b01) b_log1.push_back($signed(bus1.B_re));
      end
    end
  end

  task automatic check_log(input string name, input int got [$], input int req [$]);
    bit ok;
    ok = (got.size() == req.size());
    if (ok) foreach (req[i]) if (got[i] != req[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%p required=%p", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input int n);
    logic [EW-1:0] obs;
    logic ov;
    if (n == 0) begin
      obs = {bus4.A_re, bus4.A_im, bus4.B_re, bus4.B_im, bus4.C_re, bus4.C_im,
             bus4.D_re, bus4.D_im, bus4.sel, bus4.frame_start};
      ov  = bus4.out_valid;
    end else begin
      obs = {bus1.A_re, bus1.A_im, bus1.B_re, bus1.B_im, bus1.C_re, bus1.C_im,
             bus1.D_re, bus1.D_im, bus1.sel, bus1.frame_start};
      ov  = bus1.out_valid;
    end
    checks++;
    if (obs !== '0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_state inst%0d got=%h valid=%b required=0 valid=0", n, obs, ov);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    repeat (5) cycle(1'b0, 0, 0);

    // Fill then butterfly, then drain the differences.
    clear_logs();
    send_seq('{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0});
    repeat (2) cycle(1'b0, 0, 0);
    check_log("fill_c", c_log0, '{3, 4, 5, 6});
    check_log("fill_b", b_log0, '{-2, -2, -2, -2});
    check_log("fill_frame_start", fs_log0, '{3});

    // Scaling at the rails.
    do_reset();
    clear_logs();
    repeat (8) cycle(1'b1, 127, 0);
    repeat (4) cycle(1'b1, 127, 0);
    repeat (4) cycle(1'b1, -128, 0);
    repeat (2) cycle(1'b0, 0, 0);
    check_log("sat_c", c_log0, '{127, 127, 127, 127, -1, -1, -1, -1});
    check_log("sat_d", d_log0, '{0, 0, 0, 0, 127, 127, 127, 127});

    // Stall after sample 6.
    do_reset();
    clear_logs();
    send_seq('{1, 2, 3, 4, 5, 6});
    repeat (3) cycle(1'b0, 0, 0);
    send_seq('{7, 8});
    repeat (2) cycle(1'b0, 0, 0);
    check_log("stall_c", c_log0, '{3, 4, 5, 6});

    // Mid-frame reset.
    do_reset();
    send_seq('{1, 2, 3, 4, 5, 6});
    do_reset();
    clear_logs();
    send_seq('{1, 2, 3, 4, 5, 6, 7, 8});
    repeat (2) cycle(1'b0, 0, 0);
    check_log("midreset_c", c_log0, '{3, 4, 5, 6});
    check_log("midreset_frame_start", fs_log0, '{3});

    // DEPTH=1 alternation.
    do_reset();
    clear_logs();
    send_seq('{4, 2, 6, 2});
    repeat (2) cycle(1'b0, 0, 0);
    check_log("d1_c", c_log1, '{3, 4});
    check_log("d1_b", b_log1, '{1});
    check_log("d1_sel", sel_log1, '{2, 1, 2});

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128);
    end
    repeat (3) cycle(1'b0, 0, 0);

    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending required=0", exp_q0.size(), exp_q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
